// File: rtl/writeback_unit_if.sv
// Writeback stage bus: memory-stage inputs, decode scoreboard queries, regfile write port.
// The slave side is the writeback unit; the master side drives the stage and decode inputs.
// Outputs are a registered write port plus a combinational stall and a sticky error flag.
interface writeback_unit_if #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 4,
  parameter int OPCODEWIDTH  = 4
);
  logic                    memValid;
  logic [OPCODEWIDTH-1:0]  memOpcode;
  logic [ADDRESSWIDTH-1:0] memDestination;
  logic [WIDTH-1:0]        aluResult;
  logic [WIDTH-1:0]        memData;
  logic                    issueValid;
  logic [ADDRESSWIDTH-1:0] issueAddress;
  logic [ADDRESSWIDTH-1:0] reg1Address;
  logic [ADDRESSWIDTH-1:0] reg2Address;
  logic                    writeEnable;
  logic [ADDRESSWIDTH-1:0] writeAddress;
  logic [WIDTH-1:0]        dataToSave;
  logic                    stall;
  logic                    scoreboardError;

  modport slave (
    input  memValid, memOpcode, memDestination, aluResult, memData,
    input  issueValid, issueAddress, reg1Address, reg2Address,
    output writeEnable, writeAddress, dataToSave, stall, scoreboardError
  );

  modport master (
    output memValid, memOpcode, memDestination, aluResult, memData,
    output issueValid, issueAddress, reg1Address, reg2Address,
    input  writeEnable, writeAddress, dataToSave, stall, scoreboardError
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: registers the memory-stage result and drives the regfile write port,
// tracking pending writes per register. Latency: one cycle from memory stage to regfile write.
// Backpressure: combinational stall to decode on a read-after-pending-write or a full counter.
module writeback_unit #(
  parameter int                     WIDTH        = 8,
  parameter int                     REGNUM       = 16,
  parameter int                     ADDRESSWIDTH = 4,
  parameter int                     OPCODEWIDTH  = 4,
  parameter logic [OPCODEWIDTH-1:0] LOADOPCODE   = 4'h8,
  parameter logic [OPCODEWIDTH-1:0] STOREOPCODE  = 4'h9
) (
  input logic             clock,
  input logic             reset,
  writeback_unit_if.slave bus
);

  logic                    wb;
  logic [WIDTH-1:0]        sel_data;
  logic                    we_q;
  logic [ADDRESSWIDTH-1:0] wa_q;
  logic [WIDTH-1:0]        wd_q;
  logic                    err_q, err_d;
  logic [1:0]              cnt_q [REGNUM];
  logic [1:0]              cnt_d [REGNUM];
  logic                    commit;
  logic                    issue;
  logic                    stall;

  // Addresses beyond the register file are ignored by the scoreboard.
  function automatic logic in_range(input logic [ADDRESSWIDTH-1:0] a);
    return int'(a) < REGNUM;
  endfunction

  // A register is a hazard while it has pending writes, unless its last pending write
  // commits this cycle: the regfile writes on the falling edge, so decode sees it in time.
  function automatic logic hazard(input logic [ADDRESSWIDTH-1:0] a, input logic [1:0] c,
                                  input logic cm, input logic [ADDRESSWIDTH-1:0] wa);
    return in_range(a) && (c != 2'd0) && !(cm && (wa == a) && (c == 2'd1));
  endfunction

  assign wb       = bus.memValid && (bus.memOpcode < STOREOPCODE);
  assign sel_data = (bus.memOpcode == LOADOPCODE) ? bus.memData : bus.aluResult;
  assign commit   = we_q;
  assign issue    = bus.issueValid && !stall;

  // Decode stall: source hazards, or an issue to a register whose counter is saturated
  // and not being relieved by a same-cycle commit.
  always_comb begin
    stall = 1'b0;
    if (hazard(bus.reg1Address, cnt_q[bus.reg1Address], commit, wa_q)) stall = 1'b1;
    if (hazard(bus.reg2Address, cnt_q[bus.reg2Address], commit, wa_q)) stall = 1'b1;
    if (bus.issueValid && in_range(bus.issueAddress) &&
        (cnt_q[bus.issueAddress] == 2'd3) &&
        !(commit && (wa_q == bus.issueAddress))) stall = 1'b1;
  end

  // Scoreboard next state: issue increments, commit decrements, both together cancel.
  // A commit against an empty counter is a protocol error; the counter stays at zero.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 0; r < REGNUM; r++) begin
      if (commit && (wa_q == ADDRESSWIDTH'(r)) && (cnt_q[r] == 2'd0)) err_d = 1'b1;
      if (issue && (bus.issueAddress == ADDRESSWIDTH'(r)) &&
          !(commit && (wa_q == ADDRESSWIDTH'(r))) && (cnt_q[r] != 2'd3))
        cnt_d[r] = cnt_q[r] + 2'd1;
      else if (commit && (wa_q == ADDRESSWIDTH'(r)) &&
               !(issue && (bus.issueAddress == ADDRESSWIDTH'(r))) && (cnt_q[r] != 2'd0))
        cnt_d[r] = cnt_q[r] - 2'd1;
    end
  end

  // Write port and scoreboard state; address/data hold when nothing writes back.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
      for (int r = 0; r < REGNUM; r++) cnt_q[r] <= 2'd0;
    end else begin
      we_q  <= wb;
      if (wb) begin
        wa_q <= bus.memDestination;
        wd_q <= sel_data;
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.writeEnable     = we_q;
  assign bus.writeAddress    = wa_q;
  assign bus.dataToSave      = wd_q;
  assign bus.stall           = stall;
  assign bus.scoreboardError = err_q;

endmodule
